// File: rtl/sd_spi_master_pkg.sv
// Shared encodings for the SD card SPI master: FSM states, idle MOSI level and
// the reset value of the received-byte register.
package sd_spi_master_pkg;

    typedef enum logic [1:0] {
        SPI_IDLE = 2'd0,
        SPI_LOW  = 2'd1,
        SPI_HIGH = 2'd2
    } spi_state_t;

    localparam logic       SPI_IDLE_MOSI = 1'b1;
    localparam logic [7:0] SPI_DOUT_RST  = 8'hFF;

endpackage

// File: rtl/sd_spi_clkdiv.sv
// Phase timer for the SPI master: reloads to CLK_DIV-1 on every phase entry and
// flags phase_end while the count sits at zero.
module sd_spi_clkdiv #(
    parameter int CLK_DIV = 1
) (
    input  logic fclk,
    input  logic rst_n,
    input  logic reload,
    output logic phase_end
);

    localparam int            CW         = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0] RELOAD_VAL = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (reload) begin
            cnt <= RELOAD_VAL;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign phase_end = (cnt == '0);

endmodule

// File: rtl/sd_spi_master.sv
// SPI mode-0 byte shifter for the SD slot, MSB first, sdclk = fclk/(2*CLK_DIV).
// Build option SD_SPI_RESTART_EN: a start strobe during a transfer restarts it.
module sd_spi_master
    import sd_spi_master_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic       fclk,
    input  logic       rst_n,
    input  logic       sd_start,
    input  logic [7:0] sd_datain,
    output logic [7:0] sd_dataout,
    output logic       sdclk,
    output logic       sddo,
    input  logic       sddi,
    output logic       busy,
    output logic [1:0] dbg_state
);

    spi_state_t state;
    logic [6:0] shreg;
    logic [2:0] bitcnt;
    logic       phase_end_raw;
    logic       phase_end;
    logic       start_ok;
    logic       last_bit;
    logic       reload;

    // Handshake: sd_start is a one-fclk strobe with sd_datain valid in that cycle
    // only; busy is high from the following edge until the byte is in sd_dataout.
`ifdef SD_SPI_RESTART_EN
    assign start_ok = sd_start;
`else
    assign start_ok = sd_start && (state == SPI_IDLE);
`endif

    assign phase_end = phase_end_raw && (state != SPI_IDLE);
    assign last_bit  = (state == SPI_HIGH) && (bitcnt == 3'd7);
    assign reload    = start_ok || (phase_end && !last_bit);
    assign dbg_state = state;

    sd_spi_clkdiv #(.CLK_DIV(CLK_DIV)) u_clkdiv (
        .fclk      (fclk),
        .rst_n     (rst_n),
        .reload    (reload),
        .phase_end (phase_end_raw)
    );

    // shreg only keeps bits 6..0: bit 7 goes straight to sddo at load time.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SPI_IDLE;
            shreg      <= '0;
            bitcnt     <= '0;
            sd_dataout <= SPI_DOUT_RST;
            sdclk      <= 1'b0;
            sddo       <= SPI_IDLE_MOSI;
            busy       <= 1'b0;
        end else if (start_ok) begin
            state  <= SPI_LOW;
            shreg  <= sd_datain[6:0];
            sddo   <= sd_datain[7];
            bitcnt <= '0;
            busy   <= 1'b1;
            sdclk  <= 1'b0;
        end else if (phase_end) begin
            case (state)
                SPI_LOW: begin
                    sdclk <= 1'b1;
                    state <= SPI_HIGH;
                end
                SPI_HIGH: begin
                    sdclk <= 1'b0;
                    shreg <= {shreg[5:0], sddi};
                    if (bitcnt == 3'd7) begin
                        sd_dataout <= {shreg, sddi};
                        busy       <= 1'b0;
                        sddo       <= SPI_IDLE_MOSI;
                        state      <= SPI_IDLE;
                    end else begin
                        sddo   <= shreg[6];
                        bitcnt <= bitcnt + 3'd1;
                        state  <= SPI_LOW;
                    end
                end
                default: state <= SPI_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_spi_master.sv
// Bench for sd_spi_master: CLK_DIV=1 instance with a card model and scoreboard,
// CLK_DIV=3 instance for divider timing. Honours SD_SPI_RESTART_EN if defined.
module tb_sd_spi_master;

    logic       fclk = 1'b0;
    logic       rst_n = 1'b0;

    logic       sd_start_a = 1'b0;
    logic [7:0] datain_a = 8'h00;
    logic [7:0] dataout_a;
    logic       sdclk_a, sddo_a, busy_a;
    logic       sddi_a = 1'b1;
    logic [1:0] dbg_a;

    logic       sd_start_b = 1'b0;
    logic [7:0] datain_b = 8'h00;
    logic [7:0] dataout_b;
    logic       sdclk_b, sddo_b, busy_b;
    logic       sddi_b = 1'b0;
    logic [1:0] dbg_b;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_q[$];
    logic [7:0] mosi_q[$];

    always #5 fclk = ~fclk;

    sd_spi_master #(.CLK_DIV(1)) u_dut_a (
        .fclk(fclk), .rst_n(rst_n), .sd_start(sd_start_a), .sd_datain(datain_a),
        .sd_dataout(dataout_a), .sdclk(sdclk_a), .sddo(sddo_a), .sddi(sddi_a),
        .busy(busy_a), .dbg_state(dbg_a)
    );

    sd_spi_master #(.CLK_DIV(3)) u_dut_b (
        .fclk(fclk), .rst_n(rst_n), .sd_start(sd_start_b), .sd_datain(datain_b),
        .sd_dataout(dataout_b), .sdclk(sdclk_b), .sddo(sddo_b), .sddi(sddi_b),
        .busy(busy_b), .dbg_state(dbg_b)
    );

    // Card model: mode 0, captures MOSI on rising sdclk, shifts MISO on falling.
    logic [7:0] card_tx = 8'hFF;
    logic [7:0] card_rx = 8'h00;
    int         card_idx = 0;

    task automatic card_load(input logic [7:0] b);
        card_tx  = b;
        card_idx = 0;
        sddi_a   = b[7];
        card_rx  = 8'h00;
    endtask

    always @(posedge sdclk_a) card_rx = {card_rx[6:0], sddo_a};

    always @(negedge sdclk_a) begin
        card_idx++;
        if (card_idx < 8) sddi_a = card_tx[7-card_idx];
        else sddi_a = 1'b1;
    end

    // Scoreboard: every completed transfer pops the byte the card sent and the
    // byte the card should have received.
    logic busy_a_q = 1'b0;
    always @(negedge fclk) begin
        if (rst_n && busy_a_q && !busy_a) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: completion with dataout=%h, nothing expected", dataout_a);
            end else begin
                logic [7:0] e, m;
                e = exp_q.pop_front();
                m = mosi_q.pop_front();
                tests++;
                if (dataout_a !== e) begin
                    fails++;
                    $display("FAIL sb_dataout: got %h, expected %h", dataout_a, e);
                end
                tests++;
                if (card_rx !== m) begin
                    fails++;
                    $display("FAIL sb_mosi: card received %h, expected %h", card_rx, m);
                end
            end
        end
        busy_a_q = busy_a;
    end

    // Called at a negedge; start is sampled at the following posedge.
    task automatic start_a(input logic [7:0] d, input logic [7:0] card);
        #1;
        card_load(card);
        datain_a   = d;
        sd_start_a = 1'b1;
        @(negedge fclk);
        #1;
        sd_start_a = 1'b0;
        datain_a   = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_idle_a(input int max_cycles);
        int n;
        n = 0;
        while (busy_a === 1'b1 && n < max_cycles) begin
            @(negedge fclk);
            n++;
        end
        tests++;
        if (busy_a !== 1'b0) begin
            fails++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy_a, n);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge fclk);
            tests++;
            if (dataout_a !== 8'hFF || sdclk_a !== 1'b0 || sddo_a !== 1'b1 || busy_a !== 1'b0) begin
                fails++;
                $display("FAIL reset_a: dout=%h sdclk=%b sddo=%b busy=%b, required FF 0 1 0",
                         dataout_a, sdclk_a, sddo_a, busy_a);
            end
            tests++;
            if (dataout_b !== 8'hFF || sdclk_b !== 1'b0 || sddo_b !== 1'b1 || busy_b !== 1'b0) begin
                fails++;
                $display("FAIL reset_b: dout=%h sdclk=%b sddo=%b busy=%b, required FF 0 1 0",
                         dataout_b, sdclk_b, sddo_b, busy_b);
            end
        end
        #1;
        rst_n = 1'b1;
        @(negedge fclk);
    endtask

    task automatic test_basic;
        exp_q.push_back(8'h3C);
        mosi_q.push_back(8'hA5);
        start_a(8'hA5, 8'h3C);
        for (int k = 1; k <= 16; k++) begin
            tests++;
            if (busy_a !== 1'b1) begin
                fails++;
                $display("FAIL basic_busy: cycle %0d busy=%b, required 1", k, busy_a);
            end
            tests++;
            if (dataout_a !== 8'hFF) begin
                fails++;
                $display("FAIL basic_hold: cycle %0d dataout=%h, required FF", k, dataout_a);
            end
            @(negedge fclk);
            #1;
        end
        tests++;
        if (busy_a !== 1'b0 || dataout_a !== 8'h3C) begin
            fails++;
            $display("FAIL basic_done: busy=%b dataout=%h, required 0 3C", busy_a, dataout_a);
        end
        @(negedge fclk);
    endtask

    task automatic test_div3;
        sddi_b = 1'b0;
        #1;
        datain_b   = 8'hFF;
        sd_start_b = 1'b1;
        @(negedge fclk);
        #1;
        sd_start_b = 1'b0;
        datain_b   = 8'($urandom_range(0, 255));
        for (int k = 0; k < 48; k++) begin
            tests++;
            if (busy_b !== 1'b1 || sdclk_b !== 1'((k / 3) % 2) || sddo_b !== 1'b1) begin
                fails++;
                $display("FAIL div3_phase: cycle %0d busy=%b sdclk=%b sddo=%b, required 1 %0d 1",
                         k, busy_b, sdclk_b, sddo_b, (k / 3) % 2);
            end
            @(negedge fclk);
            #1;
        end
        tests++;
        if (busy_b !== 1'b0 || dataout_b !== 8'h00 || sdclk_b !== 1'b0) begin
            fails++;
            $display("FAIL div3_done: busy=%b dataout=%h sdclk=%b, required 0 00 0",
                     busy_b, dataout_b, sdclk_b);
        end
        @(negedge fclk);
    endtask

    task automatic test_restart;
        exp_q.push_back(8'h5A);
        mosi_q.push_back(8'hC3);
        start_a(8'hC3, 8'h5A);
        repeat (6) @(negedge fclk);
        datain_a   = 8'h11;
        sd_start_a = 1'b1;
        @(negedge fclk);
        #1;
        sd_start_a = 1'b0;
        datain_a   = 8'($urandom_range(0, 255));
`ifdef SD_SPI_RESTART_EN
        exp_q.delete();
        mosi_q.delete();
        exp_q.push_back(8'hE7);
        mosi_q.push_back(8'h11);
        card_load(8'hE7);
        tests++;
        if (busy_a !== 1'b1 || sdclk_a !== 1'b0 || dataout_a !== 8'h3C) begin
            fails++;
            $display("FAIL restart_edge: busy=%b sdclk=%b dataout=%h, required 1 0 3C",
                     busy_a, sdclk_a, dataout_a);
        end
`endif
        wait_idle_a(40);
        @(negedge fclk);
        tests++;
`ifdef SD_SPI_RESTART_EN
        if (dataout_a !== 8'hE7) begin
            fails++;
            $display("FAIL restart_result: dataout=%h, required E7", dataout_a);
        end
`else
        if (dataout_a !== 8'h5A) begin
            fails++;
            $display("FAIL restart_result: dataout=%h, required 5A", dataout_a);
        end
`endif
    endtask

    task automatic test_reset_abort;
        rst_n = 1'b0;
        @(negedge fclk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back(8'h99);
        mosi_q.push_back(8'h6D);
        start_a(8'h6D, 8'h99);
        repeat (11) @(negedge fclk);
        #1;
        tests++;
        if (sdclk_a !== 1'b1) begin
            fails++;
            $display("FAIL abort_pre: sdclk=%b in bit 5 high phase, required 1", sdclk_a);
        end
        rst_n = 1'b0;
        exp_q.delete();
        mosi_q.delete();
        #1;
        tests++;
        if (sdclk_a !== 1'b0 || busy_a !== 1'b0 || dataout_a !== 8'hFF || sddo_a !== 1'b1) begin
            fails++;
            $display("FAIL abort_now: sdclk=%b busy=%b dataout=%h sddo=%b, required 0 0 FF 1",
                     sdclk_a, busy_a, dataout_a, sddo_a);
        end
        @(negedge fclk);
        @(negedge fclk);
        #1;
        rst_n = 1'b1;
        @(negedge fclk);
        exp_q.push_back(8'h42);
        mosi_q.push_back(8'hB8);
        start_a(8'hB8, 8'h42);
        wait_idle_a(40);
        @(negedge fclk);
    endtask

    task automatic test_back_to_back;
        logic [7:0] cards [3];
        logic [7:0] outs  [3];
        cards[0] = 8'h81;
        cards[1] = 8'h7E;
        cards[2] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 3; i++) begin
            outs[i] = 8'($urandom_range(0, 255));
            exp_q.push_back(cards[i]);
            mosi_q.push_back(outs[i]);
            start_a(outs[i], cards[i]);
            tests++;
            if (busy_a !== 1'b1) begin
                fails++;
                $display("FAIL b2b_busy: transfer %0d busy=%b, required 1", i, busy_a);
            end
            wait_idle_a(40);
        end
        @(negedge fclk);
        tests++;
        if (dataout_a !== cards[2]) begin
            fails++;
            $display("FAIL b2b_last: dataout=%h, required %h", dataout_a, cards[2]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div3();
        test_restart();
        test_reset_abort();
        test_back_to_back();
        repeat (2) @(negedge fclk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: %0d transfers never completed, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
